// File: rtl/snake_matrix_scan.sv
// rtl/snake_matrix_scan.sv - 8x8 bicolour LED matrix scanner for the snake game display
// Optional head blink is enabled by defining SNAKE_HEAD_BLINK_EN.

module snake_matrix_scan #(
    parameter int DWELL = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] snake,
    input  logic [7:0]  apple,
    output logic [7:0]  dot_row,
    output logic [7:0]  dot_r,
    output logic [7:0]  dot_g,
    output logic        frame_start
);

    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_BUILD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_idx_q, row_idx_d;
    logic [3:0]    k_q, k_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [71:0]   snake_sh_q, snake_sh_d;
    logic [7:0]    apple_sh_q, apple_sh_d;
    logic [7:0]    buf_r_q, buf_r_d;
    logic [7:0]    buf_g_q, buf_g_d;
    logic [7:0]    dot_row_q, dot_row_d;
    logic [7:0]    dot_r_q, dot_r_d;
    logic [7:0]    dot_g_q, dot_g_d;
    logic          frame_start_q, frame_start_d;

`ifdef SNAKE_HEAD_BLINK_EN
    logic [4:0]    frame_cnt_q, frame_cnt_d;
    logic          head_hide_q, head_hide_d;
`endif

    logic [7:0] entry;
    logic [3:0] tens;
    logic [7:0] tens_x10;
    logic [7:0] units;
    logic       entry_valid;
    logic [2:0] entry_row;
    logic [2:0] entry_col;
    logic       hit;
    logic       head_hidden;
    logic [7:0] col_bit;
    logic [7:0] base_r;
    logic [7:0] base_g;

    // Entry k of the shadow state: 0..8 are snake segments, 9 is the apple.
    always_comb begin
        entry = apple_sh_q;
        for (int i = 0; i < 9; i++) begin
            if (k_q == 4'(i)) begin
                entry = snake_sh_q[8*i +: 8];
            end
        end
    end

    // Tens digit by range comparison keeps the decode divider-free.
    always_comb begin
        tens = 4'd0;
        for (int t = 1; t <= 8; t++) begin
            if (entry >= 8'(10 * t) && entry <= 8'(10 * t + 9)) begin
                tens = 4'(t);
            end
        end
        tens_x10    = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0};
        units       = entry - tens_x10;
        entry_valid = (entry >= 8'd12) && (entry <= 8'd89) && (units >= 8'd2);
        entry_row   = 3'(tens - 4'd1);
        entry_col   = 3'(units - 8'd2);
        hit         = entry_valid && (entry_row == row_idx_q);
        col_bit     = 8'(8'd1 << entry_col);
    end

`ifdef SNAKE_HEAD_BLINK_EN
    assign head_hidden = head_hide_q && (k_q == 4'd8);
`else
    assign head_hidden = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        k_d           = k_q;
        dwell_d       = dwell_q;
        snake_sh_d    = snake_sh_q;
        apple_sh_d    = apple_sh_q;
        buf_r_d       = buf_r_q;
        buf_g_d       = buf_g_q;
        dot_row_d     = 8'd0;
        dot_r_d       = 8'd0;
        dot_g_d       = 8'd0;
        frame_start_d = 1'b0;
        base_r        = buf_r_q;
        base_g        = buf_g_q;
`ifdef SNAKE_HEAD_BLINK_EN
        frame_cnt_d   = frame_cnt_q;
        head_hide_d   = head_hide_q;
`endif

        case (state_q)
            ST_LATCH: begin
                snake_sh_d    = snake;
                apple_sh_d    = apple;
                row_idx_d     = 3'd0;
                k_d           = 4'd0;
                dwell_d       = '0;
                frame_start_d = 1'b1;
                state_d       = ST_BUILD;
`ifdef SNAKE_HEAD_BLINK_EN
                // Hide flag uses the pre-increment count so frame 0 shows the head.
                head_hide_d   = frame_cnt_q[4];
                frame_cnt_d   = frame_cnt_q + 5'd1;
`endif
            end

            ST_BUILD: begin
                if (k_q == 4'd0) begin
                    base_r = 8'd0;
                    base_g = 8'd0;
                end
                buf_r_d = base_r;
                buf_g_d = base_g;
                if (hit && (k_q != 4'd9) && !head_hidden) begin
                    buf_r_d = base_r | col_bit;
                end
                if (hit && (k_q == 4'd9)) begin
                    buf_g_d = base_g | col_bit;
                end
                if (k_q == 4'd9) begin
                    k_d     = 4'd0;
                    dwell_d = '0;
                    state_d = ST_SHOW;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

            ST_SHOW: begin
                dot_row_d = 8'(8'd1 << row_idx_q);
                dot_r_d   = buf_r_q;
                dot_g_d   = buf_g_q;
                if (dwell_q == CW'(DWELL - 1)) begin
                    dwell_d = '0;
                    if (row_idx_q == 3'd7) begin
                        state_d = ST_LATCH;
                    end else begin
                        row_idx_d = row_idx_q + 3'd1;
                        state_d   = ST_BUILD;
                    end
                end else begin
                    dwell_d = dwell_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_LATCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_LATCH;
            row_idx_q     <= 3'd0;
            k_q           <= 4'd0;
            dwell_q       <= '0;
            snake_sh_q    <= 72'd0;
            apple_sh_q    <= 8'd0;
            buf_r_q       <= 8'd0;
            buf_g_q       <= 8'd0;
            dot_row_q     <= 8'd0;
            dot_r_q       <= 8'd0;
            dot_g_q       <= 8'd0;
            frame_start_q <= 1'b0;
`ifdef SNAKE_HEAD_BLINK_EN
            frame_cnt_q   <= 5'd0;
            head_hide_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            k_q           <= k_d;
            dwell_q       <= dwell_d;
            snake_sh_q    <= snake_sh_d;
            apple_sh_q    <= apple_sh_d;
            buf_r_q       <= buf_r_d;
            buf_g_q       <= buf_g_d;
            dot_row_q     <= dot_row_d;
            dot_r_q       <= dot_r_d;
            dot_g_q       <= dot_g_d;
            frame_start_q <= frame_start_d;
`ifdef SNAKE_HEAD_BLINK_EN
            frame_cnt_q   <= frame_cnt_d;
            head_hide_q   <= head_hide_d;
`endif
        end
    end

    assign dot_row     = dot_row_q;
    assign dot_r       = dot_r_q;
    assign dot_g       = dot_g_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// tb/tb_snake_matrix_scan.sv - scoreboard bench for snake_matrix_scan with DWELL=4

module tb_snake_matrix_scan;

    localparam int DWELL = 4;
    localparam int FRAME = 1 + 8 * (10 + DWELL);

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] snake;
    logic [7:0]  apple;
    logic [7:0]  dot_row;
    logic [7:0]  dot_r;
    logic [7:0]  dot_g;
    logic        frame_start;

    always #5 clk = ~clk;

    snake_matrix_scan #(.DWELL(DWELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .snake       (snake),
        .apple       (apple),
        .dot_row     (dot_row),
        .dot_r       (dot_r),
        .dot_g       (dot_g),
        .frame_start (frame_start)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] sb[$];
    int cyc = 0;
    int last_fs = 0;
    bit have_fs = 1'b0;
    bit want_row0 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, required event (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops one expected {row,red,green} word per lit cycle.
    always @(negedge clk) begin
        logic [23:0] exp_word;
        cyc++;
        if (!rst) begin
            have_fs   = 1'b0;
            want_row0 = 1'b0;
        end else begin
            if (frame_start) begin
                if (have_fs) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                have_fs   = 1'b1;
                last_fs   = cyc;
                want_row0 = 1'b1;
            end
            if (dot_row != 8'd0) begin
                if (want_row0) begin
                    check("row0_latency", 32'(cyc - last_fs), 32'd11);
                    want_row0 = 1'b0;
                end
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL row_unexpected: got %h, required no lit row", {dot_row, dot_r, dot_g});
                end else begin
                    exp_word = sb.pop_front();
                    check("row_pixels", {8'd0, dot_row, dot_r, dot_g}, {8'd0, exp_word});
                end
            end else begin
                check("blanking", {16'd0, dot_r, dot_g}, 32'd0);
            end
        end
    end

    task automatic push_frame(input logic [63:0] er, input logic [63:0] eg);
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < DWELL; d++) begin
                sb.push_back({8'(1 << r), er[8*r +: 8], eg[8*r +: 8]});
            end
        end
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int i = 0; i < FRAME + 20 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        if (!seen) timeout_fail("frame_start_wait");
    endtask

    task automatic wait_row(input logic [7:0] row);
        bit seen = 1'b0;
        for (int i = 0; i < FRAME + 20 && !seen; i++) begin
            @(negedge clk);
            if (dot_row == row) seen = 1'b1;
        end
        if (!seen) timeout_fail("row_wait");
    endtask

    task automatic apply(input logic [71:0] s, input logic [7:0] a,
                         input logic [63:0] er, input logic [63:0] eg);
        snake = s;
        apple = a;
        push_frame(er, eg);
        wait_fs();
    endtask

    initial begin
        rst   = 1'b0;
        snake = 72'd0;
        apple = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_dot_row", {24'd0, dot_row}, 32'd0);
        check("reset_dot_r", {24'd0, dot_r}, 32'd0);
        check("reset_dot_g", {24'd0, dot_g}, 32'd0);
        check("reset_frame_start", {31'd0, frame_start}, 32'd0);

        // Basic decode: head 12 -> row0 col0 red, apple 89 -> row7 col7 green.
        snake = {8'd12, 64'd0};
        apple = 8'd89;
        push_frame(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000);
        rst = 1'b1;
        @(negedge clk);
        check("fs_after_release", {31'd0, frame_start}, 32'd1);

        apply({8'd10, 64'd0}, 8'd11, 64'd0, 64'd0);
        apply({8'd21, 64'd0}, 8'd11, 64'd0, 64'd0);
        apply({8'd90, 64'd0}, 8'd11, 64'd0, 64'd0);
        apply({8'd0,  64'd0}, 8'd11, 64'd0, 64'd0);

        // Overlap: head, entry 7 and apple all at 45 -> row3 col3.
        apply({8'd45, 8'd45, 56'd0}, 8'd45, 64'h0000_0000_0800_0000, 64'h0000_0000_0800_0000);

        // Mixed body with invalid 31/99 and a duplicate of the head.
        apply({8'd23, 8'd0, 8'd0, 8'd23, 8'd89, 8'd31, 8'd99, 8'd72, 8'd27}, 8'd34,
              64'h8001_0000_0000_2200, 64'h0000_0000_0004_0000);

        // Corners of the valid range: 19 -> row0 col7, 82 -> row7 col0, 12 -> row0 col0.
        apply({8'd19, 56'd0, 8'd82}, 8'd12, 64'h0100_0000_0000_0080, 64'h0000_0000_0000_0001);

        // Snapshot isolation: head 12 frame, inputs swapped to 88 during row 2.
        apply({8'd12, 64'd0}, 8'd0, 64'h0000_0000_0000_0001, 64'd0);
        wait_row(8'h04);
        apply({8'd88, 64'd0}, 8'd0, 64'h4000_0000_0000_0000, 64'd0);

        // Mid-frame reset during row 3 of the head-88 frame.
        wait_row(8'h08);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midreset_dot_row", {24'd0, dot_row}, 32'd0);
            check("midreset_dot_r", {24'd0, dot_r}, 32'd0);
            check("midreset_dot_g", {24'd0, dot_g}, 32'd0);
            check("midreset_frame_start", {31'd0, frame_start}, 32'd0);
        end
        sb.delete();
        snake = {8'd12, 64'd0};
        apple = 8'd89;
        push_frame(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000);
        rst = 1'b1;
        @(negedge clk);
        check("fs_after_midreset", {31'd0, frame_start}, 32'd1);

        apply({8'd45, 8'd45, 56'd0}, 8'd45, 64'h0000_0000_0800_0000, 64'h0000_0000_0800_0000);

        for (int i = 0; i < FRAME + 20 && sb.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
